draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Shares the single VGA plot port among the sprite controllers (player, bullet, enemies). It latches each controller's one-cycle `move` pulse and grants requesters round-robin. For the granted object it erases the previously drawn square, then draws the square at its current position, one pixel per cycle. It sits between the player, enemy and bullet control blocks and the VGA adapter, and optionally performs a full-screen clear on level load.

## Interface
Parameters:
- `N_REQ`, 4: number of sprite requesters; index 0 has the highest initial priority.
- `BG_COLOUR`, 3'b000: colour used for erase and clear.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_move`  in  N_REQ  per-object one-cycle draw request (the controllers' `move`).
- `obj_x`  in  8·N_REQ  current top-left x, packed, object i at [8i+7:8i].
- `obj_y`  in  7·N_REQ  current top-left y, packed, 7 bits per object.
- `obj_w`  in  3·N_REQ  current square width; 0 = dead/invisible.
- `obj_colour`  in  3·N_REQ  draw colour per object.
- `clear_req`  in  1  one-cycle full-screen clear request.
- `vga_x`  out  8  plot x.
- `vga_y`  out  7  plot y.
- `vga_colour`  out  3  plot colour.
- `vga_plot`  out  1  plot strobe, one pixel per asserted cycle.
- `grant`  out  N_REQ  one-hot current owner; 0 when idle or clearing.
- `busy`  out  1  state ≠ IDLE.
- `clear_done`  out  1  one-cycle pulse when a clear finishes.

## Operation
- **Pending:** a pulse on `req_move[i]` sets `pend[i]`; repeat pulses while pending merge into one.
  - A pulse in the same cycle the bit is granted leaves it set (set wins).
- **Shadow registers per object:** `sh_x`, `sh_y`, `sh_w` hold the square last drawn. Reset value for all is 0, so the first erase is skipped.
- **FSM states:** IDLE, ERASE, DRAW, CLEAR.
  - **IDLE:** if clear is pending, go to CLEAR (clear beats objects). Otherwise, if any `pend` bit is set, pick the winner round-robin starting at (last grant + 1) mod N_REQ. Then:
    - latch `obj_x/y/w/colour` of the winner into `nx/ny/nw/ncol`;
    - clear its `pend` bit and assert `grant`;
    - go to ERASE.
  - **ERASE:** raster over `dy` 0..sh_w−1 (outer) and `dx` 0..sh_w−1 (inner). Drive pixel (sh_x+dx, sh_y+dy) in BG_COLOUR. If sh_w = 0, zero cycles are spent and the FSM goes straight to DRAW.
  - **DRAW:** same raster with nx/ny/nw and ncol.
    - nw = 0 spends zero cycles.
    - On the last pixel, or on entry when nw = 0, copy nx/ny/nw into the shadow registers and go to IDLE.
  - **CLEAR:** sweep x 0..159 (inner), y 0..119 (outer), 19200 cycles, in BG_COLOUR. On completion:
    - set every `sh_w` to 0;
    - pulse `clear_done`;
    - go to IDLE. Pending object requests are retained.
- **Clipping:** a pixel with x ≥ 160 or y ≥ 120 still consumes its cycle but is emitted with `vga_plot` = 0. An enemy at x = 160−w+1 therefore loses one column.
- **Arithmetic:** compute x+dx in 9 bits and y+dy in 8 bits before the clip compare; no wrap-around is allowed.
- **Stale data:** inputs are sampled only at grant. Object movement during its own transaction is picked up by its next request.

## Timing
- **Reset values:** all outputs 0; state IDLE; `pend` = 0; round-robin pointer set so index 0 wins first.
- **`resetn` low mid-transaction:** everything aborts immediately. A partially drawn sprite stays on screen; the level logic is expected to issue a clear.
- **Request latency:** `req_move` at cycle t sets `pend` at t+1. Grant is registered at the end of t+1, and the first pixel appears at t+2.
- **Outputs:** all registered; `vga_*` for a pixel are valid in the same cycle as `vga_plot`.
- **Transaction length:** 1 (IDLE) + sh_w² + nw² cycles. Back-to-back grants always pass through one IDLE cycle.
- **Clear latency:** `clear_req` at t produces the first clear pixel at t+2 if the FSM is idle. If the FSM is busy, the clear waits for the current transaction to finish.

## Configuration
- **`DRAW_SCHED_CLEAR_EN`**
  - Defined: CLEAR state, clear pending latch and `clear_done` are present as above.
  - Undefined: `clear_req` is ignored, `clear_done` is tied to 0, and the CLEAR state and its 15-bit sweep counters are not built.

## Structure
- **Package `draw_sched_pkg`:**
  - SCREEN_W = 160, SCREEN_H = 120;
  - the state enum (IDLE/ERASE/DRAW/CLEAR);
  - colour localparams (BLACK = 3'b000, WHITE = 3'b111).
- **Sub-module `rr_arbiter`:** N_REQ-wide round-robin arbiter. It takes `pend` and a pointer update strobe and returns a one-hot winner plus its index.

## Test plan
- **Single request:** obj0 at (80,115), w=3, colour 7; pulse `req_move[0]` at cycle 10 → first plot at cycle 12; 9 pixels (80..82 × 115..117) in colour 7; shadow = (80,115,3); `busy` falls at cycle 21.
- **Erase then draw:** obj0 moves to (81,115); pulse → 9 BG pixels at the old square, then 9 colour-7 pixels at the new square, 18 plotted cycles in total.
- **Round-robin:** pulse `req_move` = 4'b1111 in one cycle → grants in order 0,1,2,3. A second pulse on bit 0 during grant 1 is served after 3.
- **Clip and dead object:** enemy at (158,10), w=3 → columns 158 and 159 plotted, column 160 cycles have `vga_plot` = 0. Then w=0 → erase only, no draw, and `sh_w` becomes 0.
- **Clear:** with `DRAW_SCHED_CLEAR_EN`, `clear_req` while a request is pending → 19200 BG pixels, `clear_done` pulse, then the pending object is drawn with no erase. Without the macro → `clear_req` has no effect.
- **Async reset mid-DRAW:** assert `resetn` = 0 → `vga_plot` = 0 immediately, `pend` = 0; after release the first grant goes to index 0.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the VGA plot-port scheduler.
package draw_sched_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned SZ_W     = 3;
    localparam int unsigned COL_W    = 3;

    localparam logic [COL_W-1:0] BLACK = 3'b000;
    localparam logic [COL_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        CLEAR
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the index after the last winner.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adv,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_vld_c
);

    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        int j;
        j       = 0;
        o_gnt_c = '0;
        o_idx_c = '0;
        o_vld_c = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            j = (int'(r_ptr) + k) % int'(N_REQ);
            if (!o_vld_c && i_req[IDX_W'(j)]) begin
                o_vld_c              = 1'b1;
                o_idx_c              = IDX_W'(j);
                o_gnt_c[IDX_W'(j)]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (i_adv && o_vld_c) begin
            r_ptr <= (o_idx_c == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(o_idx_c + 1'b1);
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA plot port among sprite controllers: erase old square, draw new one.
// Optional full-screen clear is built when DRAW_SCHED_CLEAR_EN is defined.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int unsigned      N_REQ     = 4,
    parameter logic [COL_W-1:0] BG_COLOUR = BLACK
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req_move,
    input  logic [X_W*N_REQ-1:0]   obj_x,
    input  logic [Y_W*N_REQ-1:0]   obj_y,
    input  logic [SZ_W*N_REQ-1:0]  obj_w,
    input  logic [COL_W*N_REQ-1:0] obj_colour,
    input  logic                   clear_req,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   vga_plot,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   clear_done
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    logic [N_REQ-1:0]   r_pend;
    logic [X_W-1:0]     r_sh_x [N_REQ];
    logic [Y_W-1:0]     r_sh_y [N_REQ];
    logic [SZ_W-1:0]    r_sh_w [N_REQ];
    logic [IDX_W-1:0]   r_gidx;
    logic [X_W-1:0]     r_nx, r_ex;
    logic [Y_W-1:0]     r_ny, r_ey;
    logic [SZ_W-1:0]    r_nw, r_ew, r_dx, r_dy;
    logic [COL_W-1:0]   r_ncol;

    logic [X_W-1:0]     w_ox [N_REQ];
    logic [Y_W-1:0]     w_oy [N_REQ];
    logic [SZ_W-1:0]    w_ow [N_REQ];
    logic [COL_W-1:0]   w_oc [N_REQ];
    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_vld, w_take, w_clr_first, w_last, w_fin, w_emit, w_plot;
    logic [SZ_W-1:0]    w_cur_w, w_wm1, w_step_dx, w_step_dy, w_ndx, w_ndy;
    logic [X_W-1:0]     w_bx;
    logic [Y_W-1:0]     w_by;
    logic [COL_W-1:0]   w_col;
    logic [X_W:0]       w_px_x;
    logic [Y_W:0]       w_px_y;

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_ox[i] = obj_x[X_W*i +: X_W];
            w_oy[i] = obj_y[Y_W*i +: Y_W];
            w_ow[i] = obj_w[SZ_W*i +: SZ_W];
            w_oc[i] = obj_colour[COL_W*i +: COL_W];
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .i_req   (r_pend),
        .i_adv   (w_take),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_idx),
        .o_vld_c (w_vld)
    );

    assign w_take    = (r_state == IDLE) && w_vld && !w_clr_first;
    assign w_cur_w   = (r_state == ERASE) ? r_ew : r_nw;
    assign w_wm1     = w_cur_w - 3'd1;
    assign w_last    = (r_dx == w_wm1) && (r_dy == w_wm1);
    assign w_step_dx = (r_dx == w_wm1) ? '0 : r_dx + 3'd1;
    assign w_step_dy = (r_dx == w_wm1) ? r_dy + 3'd1 : r_dy;
    assign w_fin     = w_last && (((r_state == ERASE) && (r_nw == '0)) || (r_state == DRAW));

    // Selects the pixel to present on the plot port in the next cycle.
    always_comb begin
        w_emit = 1'b0;
        w_bx   = '0;
        w_by   = '0;
        w_ndx  = '0;
        w_ndy  = '0;
        w_col  = BG_COLOUR;
        case (r_state)
            IDLE: if (w_take) begin
                if (r_sh_w[w_idx] != '0) begin
                    w_emit = 1'b1;
                    w_bx   = r_sh_x[w_idx];
                    w_by   = r_sh_y[w_idx];
                end else if (w_ow[w_idx] != '0) begin
                    w_emit = 1'b1;
                    w_bx   = w_ox[w_idx];
                    w_by   = w_oy[w_idx];
                    w_col  = w_oc[w_idx];
                end
            end
            ERASE: if (!w_last) begin
                w_emit = 1'b1;
                w_bx   = r_ex;
                w_by   = r_ey;
                w_ndx  = w_step_dx;
                w_ndy  = w_step_dy;
            end else if (r_nw != '0) begin
                w_emit = 1'b1;
                w_bx   = r_nx;
                w_by   = r_ny;
                w_col  = r_ncol;
            end
            DRAW: if (!w_last) begin
                w_emit = 1'b1;
                w_bx   = r_nx;
                w_by   = r_ny;
                w_col  = r_ncol;
                w_ndx  = w_step_dx;
                w_ndy  = w_step_dy;
            end
            default: ;
        endcase
    end

    // Widened sums so off-screen pixels never wrap back onto the screen.
    assign w_px_x = (X_W+1)'(w_bx) + (X_W+1)'(w_ndx);
    assign w_px_y = (Y_W+1)'(w_by) + (Y_W+1)'(w_ndy);
    assign w_plot = w_emit && (w_px_x < (X_W+1)'(SCREEN_W)) && (w_px_y < (Y_W+1)'(SCREEN_H));

`ifdef DRAW_SCHED_CLEAR_EN
    logic           r_clr_pend, r_clear_done;
    logic [X_W-1:0] r_cx, w_cx_nxt;
    logic [Y_W-1:0] r_cy, w_cy_nxt;
    logic           w_clr_last;

    assign w_clr_first = r_clr_pend;
    assign clear_done  = r_clear_done;
    assign w_cx_nxt    = (r_cx == X_W'(SCREEN_W - 1)) ? '0 : r_cx + 1'b1;
    assign w_cy_nxt    = (r_cx == X_W'(SCREEN_W - 1)) ? r_cy + 1'b1 : r_cy;
    assign w_clr_last  = (r_state == CLEAR) && (r_cx == X_W'(SCREEN_W - 1))
                         && (r_cy == Y_W'(SCREEN_H - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_pend   <= 1'b0;
            r_clear_done <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
        end else begin
            r_clr_pend   <= (r_clr_pend && (r_state != IDLE)) || clear_req;
            r_clear_done <= w_clr_last;
            if (r_state == IDLE) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (r_state == CLEAR) begin
                r_cx <= w_cx_nxt;
                r_cy <= w_cy_nxt;
            end
        end
    end
`else
    logic w_unused_clear;
    assign w_unused_clear = clear_req;
    assign w_clr_first    = 1'b0;
    assign clear_done     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_gidx     <= '0;
            r_nx       <= '0;
            r_ny       <= '0;
            r_nw       <= '0;
            r_ncol     <= '0;
            r_ex       <= '0;
            r_ey       <= '0;
            r_ew       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
                r_sh_w[i] <= '0;
            end
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~({N_REQ{w_take}} & w_gnt)) | req_move;
            r_dx       <= w_ndx;
            r_dy       <= w_ndy;
            vga_x      <= w_px_x[X_W-1:0];
            vga_y      <= w_px_y[Y_W-1:0];
            vga_colour <= w_col;
            vga_plot   <= w_plot;
            if (w_fin) begin
                r_sh_x[r_gidx] <= r_nx;
                r_sh_y[r_gidx] <= r_ny;
                r_sh_w[r_gidx] <= r_nw;
                r_state        <= IDLE;
                grant          <= '0;
                busy           <= 1'b0;
            end
            case (r_state)
                IDLE: begin
`ifdef DRAW_SCHED_CLEAR_EN
                    if (r_clr_pend) begin
                        r_state    <= CLEAR;
                        busy       <= 1'b1;
                        vga_x      <= '0;
                        vga_y      <= '0;
                        vga_colour <= BG_COLOUR;
                        vga_plot   <= 1'b1;
                    end else
`endif
                    if (w_take) begin
                        r_gidx <= w_idx;
                        r_nx   <= w_ox[w_idx];
                        r_ny   <= w_oy[w_idx];
                        r_nw   <= w_ow[w_idx];
                        r_ncol <= w_oc[w_idx];
                        r_ex   <= r_sh_x[w_idx];
                        r_ey   <= r_sh_y[w_idx];
                        r_ew   <= r_sh_w[w_idx];
                        if (w_emit) begin
                            r_state <= (r_sh_w[w_idx] != '0) ? ERASE : DRAW;
                            grant   <= w_gnt;
                            busy    <= 1'b1;
                        end else begin
                            // Nothing to erase or draw: just record the new position.
                            r_sh_x[w_idx] <= w_ox[w_idx];
                            r_sh_y[w_idx] <= w_oy[w_idx];
                            r_sh_w[w_idx] <= w_ow[w_idx];
                        end
                    end
                end
                ERASE: if (w_last && (r_nw != '0)) r_state <= DRAW;
                DRAW: ;
`ifdef DRAW_SCHED_CLEAR_EN
                CLEAR: begin
                    if (w_clr_last) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        for (int i = 0; i < int'(N_REQ); i++) r_sh_w[i] <= '0;
                    end else begin
                        vga_x      <= w_cx_nxt;
                        vga_y      <= w_cy_nxt;
                        vga_colour <= BG_COLOUR;
                        vga_plot   <= 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed self-checking bench for draw_scheduler (clear test follows DRAW_SCHED_CLEAR_EN).
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_move = '0;
    logic [31:0] obj_x = '0;
    logic [27:0] obj_y = '0;
    logic [11:0] obj_w = '0;
    logic [11:0] obj_colour = '0;
    logic        clear_req = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [3:0]  grant;
    logic        busy;
    logic        clear_done;

    int total = 0;
    int bad = 0;

    typedef struct {
        int idx; int x; int y; int w; int col;
        int exp_busy; int exp_plots;
        int fx; int fy; int fc; int lx; int ly; int lc;
    } vec_t;

    vec_t tbl[7];

    draw_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_move   (req_move),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_colour (obj_colour),
        .clear_req  (clear_req),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .grant      (grant),
        .busy       (busy),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_obj(input int idx, input int x, input int y, input int w, input int c);
        obj_x[8*idx +: 8]      = 8'(x);
        obj_y[7*idx +: 7]      = 7'(y);
        obj_w[3*idx +: 3]      = 3'(w);
        obj_colour[3*idx +: 3] = 3'(c);
    endtask

    task automatic wait_idle(input string nm);
        int run;
        run = 0;
        for (int k = 0; k < 2000 && run < 3; k++) begin
            @(negedge clk);
            run = busy ? 0 : run + 1;
        end
        chk(nm, run, 3);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int fb_k, fall_k, fp_k, np, g, fx, fy, fc, lx, ly, lc;
        fb_k = -1; fall_k = -1; fp_k = -1; np = 0; g = 0;
        fx = 0; fy = 0; fc = 0; lx = 0; ly = 0; lc = 0;
        set_obj(v.idx, v.x, v.y, v.w, v.col);
        @(posedge clk); #1;
        req_move = 4'(1 << v.idx);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy && fb_k < 0) begin fb_k = k; g = int'(grant); end
            if (vga_plot) begin
                if (fp_k < 0) begin fp_k = k; fx = vga_x; fy = vga_y; fc = vga_colour; end
                lx = vga_x; ly = vga_y; lc = vga_colour; np++;
            end
            if (fb_k >= 0 && !busy) begin fall_k = k; break; end
            @(posedge clk); #1;
            req_move = '0;
        end
        req_move = '0;
        chk($sformatf("v%0d_busy_start", n), fb_k, 2);
        chk($sformatf("v%0d_grant", n), g, 1 << v.idx);
        chk($sformatf("v%0d_busy_len", n), fall_k - fb_k, v.exp_busy);
        chk($sformatf("v%0d_plots", n), np, v.exp_plots);
        if (v.exp_plots > 0) begin
            chk($sformatf("v%0d_first_k", n), fp_k, 2);
            chk($sformatf("v%0d_first_x", n), fx, v.fx);
            chk($sformatf("v%0d_first_y", n), fy, v.fy);
            chk($sformatf("v%0d_first_c", n), fc, v.fc);
            chk($sformatf("v%0d_last_x", n), lx, v.lx);
            chk($sformatf("v%0d_last_y", n), ly, v.ly);
            chk($sformatf("v%0d_last_c", n), lc, v.lc);
        end
    endtask

    initial begin
        int seq[5];
        int exp_seq[5];
        int ng, prevg, nb, gk;
        logic pulse_now, pulsed, seen;

        tbl[0] = '{0,  80, 115, 3, 7,  9, 9,  80, 115, 7,  82, 117, 7};
        tbl[1] = '{0,  81, 115, 3, 7, 18, 18, 80, 115, 0,  83, 117, 7};
        tbl[2] = '{2, 158,  10, 3, 5,  9, 6, 158,  10, 5, 159,  12, 5};
        tbl[3] = '{2, 158,  10, 0, 5,  9, 6, 158,  10, 0, 159,  12, 0};
        tbl[4] = '{2,  50,  50, 2, 3,  4, 4,  50,  50, 3,  51,  51, 3};
        tbl[5] = '{1,  10, 119, 2, 6,  4, 2,  10, 119, 6,  11, 119, 6};
        tbl[6] = '{3, 254,   0, 3, 1,  9, 0,   0,   0, 0,   0,   0, 0};

        // Reset state
        #12;
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_xy", int'({vga_x, vga_y, vga_colour}), 0);
        chk("rst_clear_done", int'(clear_done), 0);
        #11 resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // Round-robin with a re-request of bit 0 while bit 1 owns the port
        for (int i = 0; i < 4; i++) set_obj(i, 20 + 10*i, 20, 1, i + 1);
        exp_seq = '{1, 2, 4, 8, 1};
        seq = '{0, 0, 0, 0, 0};
        ng = 0; prevg = 0; pulse_now = 1'b0; pulsed = 1'b0;
        @(posedge clk); #1;
        req_move = 4'b1111;
        for (int k = 0; k < 500 && ng < 5; k++) begin
            @(negedge clk);
            if (grant != 4'b0000 && prevg == 0) begin
                seq[ng] = int'(grant);
                ng++;
                if (grant == 4'b0010 && !pulsed) pulse_now = 1'b1;
            end
            prevg = int'(grant);
            @(posedge clk); #1;
            req_move = pulse_now ? 4'b0001 : 4'b0000;
            if (pulse_now) begin pulse_now = 1'b0; pulsed = 1'b1; end
        end
        req_move = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), seq[i], exp_seq[i]);
        wait_idle("rr_idle");

        // Asynchronous reset in the middle of a draw
        set_obj(0, 30, 30, 4, 2);
        set_obj(2, 60, 60, 2, 4);
        @(posedge clk); #1; req_move = 4'b0001;
        @(posedge clk); #1; req_move = 4'b0000;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (vga_plot && vga_colour == 3'd2) seen = 1'b1;
        end
        chk("rst_mid_reached_draw", int'(seen), 1);
        @(posedge clk); #1; req_move = 4'b0100;
        @(posedge clk); #1; req_move = 4'b0000;
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_plot", int'(vga_plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_grant", int'(grant), 0);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("rst_pend_cleared", nb, 0);
        @(posedge clk); #1; req_move = 4'b1111;
        gk = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) gk = int'(grant);
            @(posedge clk); #1;
            req_move = 4'b0000;
        end
        chk("rst_first_grant", gk, 1);
        wait_idle("rst_idle");

`ifdef DRAW_SCHED_CLEAR_EN
        begin
            int ndone, done_k, nbg, fk, fx, fy, lx, ly, obj_k, nobj, nother;
            ndone = 0; done_k = -1; nbg = 0; fk = -1; fx = -1; fy = -1;
            lx = -1; ly = -1; obj_k = -1; nobj = 0; nother = 0;
            set_obj(1, 20, 30, 2, 6);
            @(posedge clk); #1;
            req_move = 4'b0010;
            clear_req = 1'b1;
            for (int k = 0; k < 19400; k++) begin
                @(negedge clk);
                if (clear_done) begin ndone++; done_k = k; end
                if (vga_plot) begin
                    if (done_k < 0) begin
                        if (vga_colour == 3'd0) nbg++;
                        if (fk < 0) begin fk = k; fx = vga_x; fy = vga_y; end
                        lx = vga_x; ly = vga_y;
                    end else begin
                        if (obj_k < 0) obj_k = k;
                        if (vga_colour == 3'd6) nobj++; else nother++;
                    end
                end
                if (done_k >= 0 && k > done_k + 1 && !busy) break;
                @(posedge clk); #1;
                req_move = 4'b0000;
                clear_req = 1'b0;
            end
            req_move = 4'b0000;
            clear_req = 1'b0;
            chk("clr_first_k", fk, 2);
            chk("clr_first_xy", fx * 1000 + fy, 0);
            chk("clr_last_xy", lx * 1000 + ly, 159 * 1000 + 119);
            chk("clr_bg_pixels", nbg, 19200);
            chk("clr_done_count", ndone, 1);
            chk("clr_done_k", done_k, 19202);
            chk("clr_obj_first_k", obj_k, 19203);
            chk("clr_obj_pixels", nobj, 4);
            chk("clr_obj_no_erase", nother, 0);
        end
`else
        begin
            int nact;
            nact = 0;
            @(posedge clk); #1; clear_req = 1'b1;
            @(posedge clk); #1; clear_req = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (busy || clear_done || vga_plot) nact++;
            end
            chk("clr_ignored", nact, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
